// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl: 4x4 keypad scanner with password entry, unlock pulse and lockout.
//
// Scans one keypad row at a time, debounces a single pressed key, applies its action
// once per press and waits for a debounced release before it scans again. Digit keys
// 0-B shift into the entry buffer. D is backspace, C clears the entry, F clears the
// entry and the failure count, and E submits the entry. MAX_FAIL wrong submissions in
// a row lock the keypad for LOCK_CYCLES cycles.
//
// Optional feature macro: KEYPAD_AUTO_RELOCK_EN adds the `relock` output. After an
// unlock, LOCK_CYCLES idle cycles (scanning with an empty buffer) produce one relock pulse.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high
//   password    in   expected code; digit 0 (most recent key) in [3:0]
//   col         in   keypad columns, active-low
//   row         out  row drive, one-hot-low
//   buffer      out  entered digits; newest in [3:0]
//   valid       out  valid[i] set when digit i holds an entered key
//   key_strobe  out  one-cycle pulse per accepted key
//   key_code    out  code of the last accepted key
//   unlock      out  one-cycle pulse on a correct entry
//   is_wrong    out  level; last entry was wrong
//   locked_out  out  level; lockout active
//   fail_count  out  consecutive wrong attempts
//   relock      out  (KEYPAD_AUTO_RELOCK_EN only) one-cycle auto-relock pulse
module keypad_lock_ctrl #(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned SETTLE      = 2,
  parameter int unsigned DEBOUNCE    = 8,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [4*N_DIGITS-1:0]           password,
  input  logic [3:0]                      col,
  output logic [3:0]                      row,
  output logic [4*N_DIGITS-1:0]           buffer,
  output logic [N_DIGITS-1:0]             valid,
  output logic                            key_strobe,
  output logic [3:0]                      key_code,
  output logic                            unlock,
  output logic                            is_wrong,
  output logic                            locked_out,
`ifdef KEYPAD_AUTO_RELOCK_EN
  output logic                            relock,
`endif
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

  localparam int BW = 4 * N_DIGITS;
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {StScan, StDeb, StAct, StRel, StLock} state_t;

  state_t          state;
  logic [1:0]      sel;
  logic [SW-1:0]   scan_cnt;
  logic [DW-1:0]   deb_cnt;
  logic [LW-1:0]   lock_cnt;
  logic [3:0]      cap_col;
  logic [3:0]      act_code;
  logic            entry_ok;

  // Row pattern driven for a given scan index.
  function automatic logic [3:0] row_of(input logic [1:0] s);
    case (s)
      2'd0:    return 4'b0111;
      2'd1:    return 4'b1011;
      2'd2:    return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic single_low(input logic [3:0] c);
    return (c == 4'b0111) || (c == 4'b1011) || (c == 4'b1101) || (c == 4'b1110);
  endfunction

  // Key code at the crossing of scan row s and column pattern c.
  function automatic logic [3:0] decode_key(input logic [1:0] s, input logic [3:0] c);
    case ({s, c})
      {2'd0, 4'b0111}: return 4'hF;
      {2'd0, 4'b1011}: return 4'hE;
      {2'd0, 4'b1101}: return 4'hD;
      {2'd0, 4'b1110}: return 4'hC;
      {2'd1, 4'b0111}: return 4'hA;
      {2'd1, 4'b1011}: return 4'h3;
      {2'd1, 4'b1101}: return 4'h6;
      {2'd1, 4'b1110}: return 4'h9;
      {2'd2, 4'b0111}: return 4'hB;
      {2'd2, 4'b1011}: return 4'h2;
      {2'd2, 4'b1101}: return 4'h5;
      {2'd2, 4'b1110}: return 4'h8;
      {2'd3, 4'b0111}: return 4'h0;
      {2'd3, 4'b1011}: return 4'h1;
      {2'd3, 4'b1101}: return 4'h4;
      default:         return 4'h7;
    endcase
  endfunction

  assign act_code = decode_key(sel, cap_col);
  assign entry_ok = (&valid) && (buffer == password);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StScan;
      sel        <= 2'd0;
      row        <= 4'b0111;
      scan_cnt   <= '0;
      deb_cnt    <= '0;
      lock_cnt   <= '0;
      cap_col    <= 4'hF;
      buffer     <= '0;
      valid      <= '0;
      key_strobe <= 1'b0;
      key_code   <= 4'h0;
      unlock     <= 1'b0;
      is_wrong   <= 1'b0;
      locked_out <= 1'b0;
      fail_count <= '0;
    end else begin
      key_strobe <= 1'b0;
      unlock     <= 1'b0;
      unique case (state)
        StScan: begin
          if (scan_cnt == SW'(SETTLE - 1)) begin
            scan_cnt <= '0;
            if (single_low(col)) begin
              cap_col <= col;
              deb_cnt <= '0;
              state   <= StDeb;
            end else begin
              sel <= sel + 2'd1;
              row <= row_of(sel + 2'd1);
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end

        StDeb: begin
          if (col == cap_col) begin
            if (deb_cnt == DW'(DEBOUNCE - 1)) begin
              state <= StAct;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            // Bounce: rescan the same row from the start of its settle window.
            state <= StScan;
          end
        end

        StAct: begin
          key_strobe <= 1'b1;
          key_code   <= act_code;
          deb_cnt    <= '0;
          state      <= StRel;
          if (act_code <= 4'hB) begin
            if (!(&valid)) begin
              buffer <= (buffer << 4) | BW'(act_code);
              valid  <= (valid << 1) | N_DIGITS'(1);
            end
          end else if (act_code == 4'hD) begin
            buffer <= buffer >> 4;
            valid  <= valid >> 1;
          end else if (act_code == 4'hC) begin
            buffer   <= '0;
            valid    <= '0;
            is_wrong <= 1'b0;
          end else if (act_code == 4'hF) begin
            buffer     <= '0;
            valid      <= '0;
            is_wrong   <= 1'b0;
            fail_count <= '0;
          end else begin
            buffer <= '0;
            valid  <= '0;
            if (entry_ok) begin
              unlock     <= 1'b1;
              is_wrong   <= 1'b0;
              fail_count <= '0;
            end else begin
              is_wrong   <= 1'b1;
              fail_count <= fail_count + 1'b1;
              if (fail_count == FW'(MAX_FAIL - 1)) begin
                locked_out <= 1'b1;
                lock_cnt   <= '0;
                scan_cnt   <= '0;
                state      <= StLock;
              end
            end
          end
        end

        StRel: begin
          if (col == 4'b1111) begin
            if (deb_cnt == DW'(DEBOUNCE - 1)) begin
              scan_cnt <= '0;
              state    <= StScan;
            end else begin
              deb_cnt <= deb_cnt + 1'b1;
            end
          end else begin
            deb_cnt <= '0;
          end
        end

        StLock: begin
          // Rows keep cycling so the scan resumes naturally; columns are ignored.
          if (scan_cnt == SW'(SETTLE - 1)) begin
            scan_cnt <= '0;
            sel      <= sel + 2'd1;
            row      <= row_of(sel + 2'd1);
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
          if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
            locked_out <= 1'b0;
            fail_count <= '0;
            scan_cnt   <= '0;
            state      <= StScan;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        default: state <= StScan;
      endcase
    end
  end

`ifdef KEYPAD_AUTO_RELOCK_EN
  logic          relock_pending;
  logic [LW-1:0] relock_cnt;

  // Idle timer: advances only while scanning with an empty entry; any key restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      relock         <= 1'b0;
      relock_pending <= 1'b0;
      relock_cnt     <= '0;
    end else begin
      relock <= 1'b0;
      if (state == StAct) begin
        relock_cnt <= '0;
        if (act_code == 4'hE && entry_ok) begin
          relock_pending <= 1'b1;
        end
      end else if (relock_pending && state == StScan && valid == '0) begin
        if (relock_cnt == LW'(LOCK_CYCLES - 1)) begin
          relock         <= 1'b1;
          relock_pending <= 1'b0;
          relock_cnt     <= '0;
        end else begin
          relock_cnt <= relock_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule
